// File: rtl/multi_phase_signal_control_if.sv
// rtl/multi_phase_signal_control_if.sv - signal bundle between the controller and its environment
// Purpose: groups timebase, sensor inputs and light/phase outputs of multi_phase_signal_control.
// Ports (signals):
//   tick         timebase strobe (master -> controller)
//   req          per-approach vehicle sensors, level (master -> controller)
//   lights       2 bits per approach, RED=0 YELLOW=1 GREEN=2 (controller -> master)
//   active       approach owning the right of way (controller -> master)
//   phase        0=GREEN 1=YELLOW 2=ALLRED (controller -> master)
//   preempt      emergency request, present only with PREEMPT_EN (master -> controller)
//   preempt_sel  approach to preempt to, present only with PREEMPT_EN (master -> controller)
interface multi_phase_signal_control_if #(
  parameter int N_APPR = 4
) ();
  localparam int IDX_W = $clog2(N_APPR);

  logic                  tick;
  logic [N_APPR-1:0]     req;
  logic [2*N_APPR-1:0]   lights;
  logic [IDX_W-1:0]      active;
  logic [1:0]            phase;
`ifdef PREEMPT_EN
  logic                  preempt;
  logic [IDX_W-1:0]      preempt_sel;

  modport master (output tick, req, preempt, preempt_sel, input lights, active, phase);
  modport slave  (input tick, req, preempt, preempt_sel, output lights, active, phase);
`else
  modport master (output tick, req, input lights, active, phase);
  modport slave  (input tick, req, output lights, active, phase);
`endif
endinterface

// File: rtl/multi_phase_signal_control.sv
// rtl/multi_phase_signal_control.sv - N-approach tick-timed traffic signal controller
// Purpose: cycles GREEN -> YELLOW -> ALLRED -> next GREEN, serving latched requests
//   round-robin with min/max green limits, resting on HOME when there is no demand.
//   Optional emergency preemption is compiled in when the macro PREEMPT_EN is defined.
// Ports:
//   clock   system clock, rising edge
//   clear   asynchronous active-high reset
//   sig     multi_phase_signal_control_if.slave: tick, req, [preempt, preempt_sel] in;
//           lights, active, phase out (all registered)
module multi_phase_signal_control #(
  parameter int N_APPR    = 4,
  parameter int HOME      = 0,
  parameter int CNT_W     = 8,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2
) (
  input  logic                               clock,
  input  logic                               clear,
  multi_phase_signal_control_if.slave        sig
);
  localparam int IDX_W = $clog2(N_APPR);

  generate
    if (N_APPR < 2 || N_APPR > 8) begin : g_bad_n
      $error("N_APPR must be in 2..8");
    end
    if (HOME < 0 || HOME >= N_APPR) begin : g_bad_home
      $error("HOME must be a valid approach index");
    end
    if (CNT_W < 1 || CNT_W > 30) begin : g_bad_cnt_w
      $error("CNT_W must be in 1..30");
    end
    if (MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN || MAX_GREEN >= (1 << CNT_W)) begin : g_bad_green
      $error("need 1 <= MIN_GREEN <= MAX_GREEN < 2**CNT_W");
    end
    if (YELLOW_T < 1 || YELLOW_T >= (1 << CNT_W) || ALLRED_T < 1 || ALLRED_T >= (1 << CNT_W)) begin : g_bad_clear
      $error("YELLOW_T and ALLRED_T must be in 1..2**CNT_W-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    ALLRED = 2'd2
  } phase_t;

  localparam logic [IDX_W-1:0] HOME_I = IDX_W'(HOME);
  localparam logic [CNT_W-1:0] MIN_G  = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MAX_G  = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] YEL_T  = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] AR_T   = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] T_SAT  = '1;

  phase_t              phase_q;
  logic [IDX_W-1:0]    active_q;
  logic [IDX_W-1:0]    target_q;
  logic [CNT_W-1:0]    timer_q;
  logic [N_APPR-1:0]   pend_q;
  logic [2*N_APPR-1:0] lights_q;

  phase_t              nxt_phase;
  logic [IDX_W-1:0]    nxt_active;
  logic [IDX_W-1:0]    nxt_target;
  logic [CNT_W-1:0]    nxt_timer;
  logic [N_APPR-1:0]   nxt_pend;
  logic [CNT_W-1:0]    cnt;
  logic [N_APPR-1:0]   act_mask;
  logic [N_APPR-1:0]   others;
  logic [IDX_W-1:0]    scan_tgt;
  logic [IDX_W-1:0]    idx;
  logic                found;

  // Only the owning approach ever shows a colour; everyone else is RED.
  function automatic logic [2*N_APPR-1:0] decode(input phase_t ph, input logic [IDX_W-1:0] a);
    logic [1:0] code;
    decode = '0;
    code = (ph == GREEN) ? 2'd2 : (ph == YELLOW) ? 2'd1 : 2'd0;
    for (int i = 0; i < N_APPR; i++) begin
      if (IDX_W'(i) == a) decode[2*i +: 2] = code;
    end
  endfunction

  always_comb begin
    // cnt is the timer value including this cycle's tick, saturating.
    cnt = (sig.tick && timer_q != T_SAT) ? timer_q + 1'b1 : timer_q;

    act_mask = '0;
    act_mask[active_q] = 1'b1;
    others = pend_q & ~act_mask;

    // Round-robin: first pending approach after the active one, wrapping.
    scan_tgt = active_q;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k < N_APPR; k++) begin
      idx = IDX_W'((int'(active_q) + k) % N_APPR);
      if (!found && others[idx]) begin
        scan_tgt = idx;
        found    = 1'b1;
      end
    end

    nxt_phase  = phase_q;
    nxt_active = active_q;
    nxt_target = target_q;
    case (phase_q)
      GREEN: begin
        if (sig.tick && cnt >= MIN_G) begin
          if (found && (!sig.req[active_q] || cnt >= MAX_G)) begin
            nxt_phase  = YELLOW;
            nxt_target = scan_tgt;
          end else if (!found && active_q != HOME_I && !sig.req[active_q]) begin
            nxt_phase  = YELLOW;
            nxt_target = HOME_I;
          end
        end
      end
      YELLOW: begin
        if (sig.tick && cnt == YEL_T) nxt_phase = ALLRED;
      end
      ALLRED: begin
        if (sig.tick && cnt == AR_T) begin
          nxt_phase  = GREEN;
          nxt_active = target_q;
        end
      end
      default: begin
        nxt_phase = GREEN;
      end
    endcase

`ifdef PREEMPT_EN
    // Preemption overrides the normal green decision; clearance timing is untouched.
    if (sig.preempt) begin
      case (phase_q)
        GREEN: begin
          if (sig.preempt_sel == active_q || !sig.tick) begin
            nxt_phase  = GREEN;
            nxt_target = target_q;
          end else begin
            nxt_phase  = YELLOW;
            nxt_target = sig.preempt_sel;
          end
        end
        default: begin
          nxt_target = sig.preempt_sel;
          if (nxt_phase == GREEN) nxt_active = sig.preempt_sel;
        end
      endcase
    end
`endif

    nxt_pend = pend_q | (sig.req & ~act_mask);
    if (phase_q == ALLRED && nxt_phase == GREEN) nxt_pend[nxt_active] = 1'b0;

    nxt_timer = (nxt_phase != phase_q) ? '0 : cnt;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      phase_q  <= GREEN;
      active_q <= HOME_I;
      target_q <= HOME_I;
      timer_q  <= '0;
      pend_q   <= '0;
      lights_q <= decode(GREEN, HOME_I);
    end else begin
      phase_q  <= nxt_phase;
      active_q <= nxt_active;
      target_q <= nxt_target;
      timer_q  <= nxt_timer;
      pend_q   <= nxt_pend;
      lights_q <= decode(nxt_phase, nxt_active);
    end
  end

  assign sig.lights = lights_q;
  assign sig.active = active_q;
  assign sig.phase  = phase_q;
endmodule
